// File: rtl/pwm_tx_pkg.sv
// Shared types and defaults for the PWM transmit engine.
package pwm_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SYM  = 2'd2
  } state_e;

  localparam int DEF_PERIOD = 10;
  localparam int DEF_HI1    = 8;
  localparam int DEF_HI0    = 2;

  // Picks the symbol bit for the requested transmission order.
  function automatic logic order_bit(input logic msb_first, input logic lsb_val,
                                     input logic msb_val);
    return msb_first ? msb_val : lsb_val;
  endfunction

endpackage

// File: rtl/pwm_tx_engine_timer.sv
// Base-tick and unit counters for one PWM symbol; exposes next unit value and end-of-symbol strobe.
module pwm_sym_timer
  import pwm_tx_pkg::*;
#(
  parameter int CNT_W  = 22,
  parameter int MULT_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run_i,
  input  logic [CNT_W-1:0]  base_i,
  input  logic [MULT_W-1:0] period_i,
  output logic [MULT_W-1:0] unit_next_o,
  output logic              sym_end_o
);

  logic [CNT_W-1:0]  tick_q, tick_d;
  logic [MULT_W-1:0] unit_q, unit_d;
  logic              tick_wrap, unit_wrap;

  assign tick_wrap = (tick_q == base_i - CNT_W'(1));
  assign unit_wrap = (unit_q == period_i - MULT_W'(1));

  // Counters sit at zero whenever the symbol is not running, so every symbol starts clean.
  always_comb begin
    tick_d = '0;
    unit_d = '0;
    if (run_i) begin
      tick_d = tick_wrap ? '0 : tick_q + CNT_W'(1);
      unit_d = unit_q;
      if (tick_wrap) unit_d = unit_wrap ? '0 : unit_q + MULT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_q <= '0;
      unit_q <= '0;
    end else begin
      tick_q <= tick_d;
      unit_q <= unit_d;
    end
  end

  assign unit_next_o = unit_d;
  assign sym_end_o   = run_i & tick_wrap & unit_wrap;

endmodule

// File: rtl/pwm_tx_engine.sv
// PWM bit serialiser: pops show-ahead FIFO words and sends each bit as one programmable PWM symbol.
module pwm_tx_engine
  import pwm_tx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 22,
  parameter int MULT_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [CNT_W-1:0]  base_counter,
  input  logic [MULT_W-1:0] mult_period,
  input  logic [MULT_W-1:0] mult_hi1,
  input  logic [MULT_W-1:0] mult_hi0,
  input  logic              msb_first,
  input  logic              start_tx,
  input  logic              abort,
  input  logic [DATA_W-1:0] fifo_din,
  input  logic              fifo_empty,
  output logic              fifo_re,
  output logic              pwm_out,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d, shreg_rev;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  base_q, base_d;
  logic [MULT_W-1:0] per_q, per_d, hi1_q, hi1_d, hi0_q, hi0_d;
  logic              msb_q, msb_d;
  logic              pwm_q, pwm_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic              run, sym_end, last_bit, word_end, sym_bit;
  logic [MULT_W-1:0] unit_next, hi_sel;

  assign run      = (state_q == ST_SYM) && !abort;
  assign last_bit = (idx_q == IDX_W'(DATA_W - 1));
  assign word_end = sym_end && last_bit;

  pwm_sym_timer #(.CNT_W(CNT_W), .MULT_W(MULT_W)) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .run_i      (run),
    .base_i     (base_q),
    .period_i   (per_q),
    .unit_next_o(unit_next),
    .sym_end_o  (sym_end)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!abort && start_tx && mult_period != '0 && !fifo_empty) state_d = ST_LOAD;
      ST_LOAD: state_d = abort ? ST_IDLE : ST_SYM;
      ST_SYM:  if (abort || (word_end && fifo_empty)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_re   = !abort && ((state_q == ST_LOAD) || (state_q == ST_SYM && word_end && !fifo_empty));
    done_d    = (state_q == ST_SYM) && word_end && fifo_empty;
    cfg_err_d = (state_q == ST_IDLE) && !abort && start_tx && (mult_period == '0);
    busy      = (state_q != ST_IDLE);
  end

  // Configuration is captured during LOAD and frozen for the rest of the frame.
  always_comb begin
    base_d  = base_q;
    per_d   = per_q;
    hi1_d   = hi1_q;
    hi0_d   = hi0_q;
    msb_d   = msb_q;
    if (state_q == ST_LOAD) begin
      base_d = (base_counter == '0) ? CNT_W'(1) : base_counter;
      per_d  = mult_period;
      hi1_d  = mult_hi1;
      hi0_d  = mult_hi0;
      msb_d  = msb_first;
    end
    shreg_d = fifo_re ? fifo_din : shreg_q;
    idx_d   = idx_q;
    if (state_q == ST_LOAD)               idx_d = '0;
    else if (state_q == ST_SYM && sym_end) idx_d = last_bit ? '0 : idx_q + IDX_W'(1);
  end

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rev
      assign shreg_rev[gi] = shreg_d[DATA_W-1-gi];
    end
  endgenerate

  // The line register takes the level of the cycle being entered, so high starts right after LOAD.
  always_comb begin
    sym_bit = order_bit(msb_d, shreg_d[idx_d], shreg_rev[idx_d]);
    hi_sel  = sym_bit ? hi1_d : hi0_d;
    pwm_d   = (state_d == ST_SYM) && (unit_next < hi_sel);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shreg_q   <= '0;
      idx_q     <= '0;
      base_q    <= '0;
      per_q     <= '0;
      hi1_q     <= '0;
      hi0_q     <= '0;
      msb_q     <= 1'b0;
      pwm_q     <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      base_q    <= base_d;
      per_q     <= per_d;
      hi1_q     <= hi1_d;
      hi0_q     <= hi0_d;
      msb_q     <= msb_d;
      pwm_q     <= pwm_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign pwm_out = pwm_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule
